// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: takes parallel words over a valid/ready handshake and
// shifts them out MSB-first, one bit per clock, onto a single-bit stream.
// Drives IDLE_BIT between words and counts completed words (mod 256).
// Optional macro SERIAL_FEEDER_PARITY_EN appends one even-parity bit per word.
module serial_bit_feeder #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             busy,
    output logic [7:0]       word_count
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

`ifdef SERIAL_FEEDER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PARITY = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [7:0]       wc_q, wc_d;
    logic             xfer;
`ifdef SERIAL_FEEDER_PARITY_EN
    logic             parity_q, parity_d;
`endif

    assign xfer = din_valid & din_ready;

    // Ready when a new word can be loaded at the coming edge; held low during reset.
    always_comb begin
        din_ready = 1'b0;
        if (!reset) begin
            unique case (state_q)
                IDLE:    din_ready = 1'b1;
`ifdef SERIAL_FEEDER_PARITY_EN
                PARITY:  din_ready = 1'b1;
                default: din_ready = 1'b0;
`else
                SHIFT:   din_ready = (cnt_q == LAST);
                default: din_ready = 1'b0;
`endif
            endcase
        end
    end

    // Next-state logic: load on transfer, shift otherwise, count finished words.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        cnt_d    = cnt_q;
        wc_d     = wc_q;
`ifdef SERIAL_FEEDER_PARITY_EN
        parity_d = parity_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d  = SHIFT;
                    shift_d  = din;
                    cnt_d    = '0;
`ifdef SERIAL_FEEDER_PARITY_EN
                    parity_d = ^din;
`endif
                end
            end
            SHIFT: begin
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    cnt_d = '0;
`ifdef SERIAL_FEEDER_PARITY_EN
                    state_d = PARITY;
`else
                    wc_d = wc_q + 8'd1;
                    if (xfer) begin
                        shift_d = din;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            PARITY: begin
                wc_d = wc_q + 8'd1;
                if (xfer) begin
                    state_d  = SHIFT;
                    shift_d  = din;
                    cnt_d    = '0;
                    parity_d = ^din;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            cnt_q    <= '0;
            wc_q     <= '0;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            wc_q     <= wc_d;
`ifdef SERIAL_FEEDER_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Serial outputs decoded from registered state only; forced idle during reset.
    always_comb begin
        x           = IDLE_BIT;
        x_valid     = 1'b0;
        frame_start = 1'b0;
        busy        = 1'b0;
        if (!reset) begin
            busy = (state_q != IDLE);
            if (state_q == SHIFT) begin
                x           = shift_q[WIDTH-1];
                x_valid     = 1'b1;
                frame_start = (cnt_q == '0);
            end
`ifdef SERIAL_FEEDER_PARITY_EN
            if (state_q == PARITY) begin
                x       = parity_q;
                x_valid = 1'b1;
            end
`endif
        end
    end

    assign word_count = wc_q;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder (WIDTH=8, IDLE_BIT=0).
// Works in both builds; SERIAL_FEEDER_PARITY_EN selects the 9-cycle frame table.
module tb_serial_bit_feeder;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       din_ready, x, x_valid, frame_start, busy;
    logic [7:0] word_count;

    int unsigned nvec = 0;
    int unsigned nerr = 0;

    serial_bit_feeder #(.WIDTH(8), .IDLE_BIT(1'b0)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .x(x), .x_valid(x_valid),
        .frame_start(frame_start), .busy(busy), .word_count(word_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] din;
        logic       dv;
        logic       ex, exv, efs, ebusy, erdy;
        logic [7:0] ewc;
    } vec_t;

    vec_t tbl[$];

`ifdef SERIAL_FEEDER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    task automatic push(input logic rst, input logic [7:0] d, input logic dv,
                        input logic ex, input logic exv, input logic efs,
                        input logic eb, input logic er, input logic [7:0] ewc);
        vec_t v;
        v.rst = rst; v.din = d; v.dv = dv;
        v.ex = ex; v.exv = exv; v.efs = efs; v.ebusy = eb; v.erdy = er; v.ewc = ewc;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s vec=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    logic [17:0] seq;
    logic [8:0]  seq07;
    int unsigned acc, cyc;

    initial begin
`ifdef SERIAL_FEEDER_PARITY_EN
        seq   = 18'b101001010_001111000;
        seq07 = 9'b000001111;
`else
        seq   = {16'b10100101_00111100, 2'b00};
        seq07 = 9'b0;
`endif
        // second reset cycle, then idle ready
        push(1, 8'h00, 0, 0, 0, 0, 0, 0, 8'd0);
        // single word A5; din changed to 00 after acceptance
        push(0, 8'hA5, 1, 0, 0, 0, 0, 1, 8'd0);
        for (int i = 0; i < FL; i++)
            push(0, 8'h00, 0, seq[17-i], 1, (i == 0), 1, (i == FL-1), 8'd0);
        push(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'd1);
        // back-to-back A5 then 3C, 3C presented while not ready
        push(0, 8'hA5, 1, 0, 0, 0, 0, 1, 8'd1);
        for (int i = 0; i < 2*FL; i++)
            push(0, (i < FL) ? 8'h3C : 8'h00, (i < FL), seq[17-i], 1,
                 (i == 0 || i == FL), 1, (i == FL-1 || i == 2*FL-1),
                 (i < FL) ? 8'd1 : 8'd2);
        push(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'd3);
        // FF interrupted by reset during its 4th bit, with a word offered
        push(0, 8'hFF, 1, 0, 0, 0, 0, 1, 8'd3);
        for (int i = 0; i < 3; i++)
            push(0, 8'h00, 0, 1, 1, (i == 0), 1, 0, 8'd3);
        push(1, 8'h55, 1, 0, 0, 0, 0, 0, 8'd3);
        push(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'd0);
        push(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'd0);
`ifdef SERIAL_FEEDER_PARITY_EN
        // 07 has odd weight, so parity bit is 1
        push(0, 8'h07, 1, 0, 0, 0, 0, 1, 8'd0);
        for (int i = 0; i < 9; i++)
            push(0, 8'h00, 0, seq07[8-i], 1, (i == 0), 1, (i == 8), 8'd0);
        push(0, 8'h00, 0, 0, 0, 0, 0, 1, 8'd1);
`endif

        foreach (tbl[k]) begin
            @(posedge clk); #1;
            reset = tbl[k].rst; din = tbl[k].din; din_valid = tbl[k].dv;
            @(negedge clk);
            nvec++;
            chk("x",           k, {7'd0, x},           {7'd0, tbl[k].ex});
            chk("x_valid",     k, {7'd0, x_valid},     {7'd0, tbl[k].exv});
            chk("frame_start", k, {7'd0, frame_start}, {7'd0, tbl[k].efs});
            chk("busy",        k, {7'd0, busy},        {7'd0, tbl[k].ebusy});
            chk("din_ready",   k, {7'd0, din_ready},   {7'd0, tbl[k].erdy});
            chk("word_count",  k, word_count,          tbl[k].ewc);
        end

        // 256 back-to-back words wrap the count to 0, one more gives 1
        @(posedge clk); #1 reset = 1'b1; din_valid = 1'b0;
        @(posedge clk); #1 reset = 1'b0; din = 8'h5A; din_valid = 1'b1;
        acc = 0; cyc = 0;
        while (acc < 256 && cyc < 5000) begin
            @(negedge clk);
            if (din_valid && din_ready) acc++;
            @(posedge clk); #1;
            if (acc == 256) din_valid = 1'b0;
            cyc++;
        end
        nvec++;
        chk("accept_256", 0, {7'd0, acc == 256}, 8'd1);
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (busy && cyc < 50);
        nvec++;
        chk("wrap_idle", 0, {7'd0, busy}, 8'd0);
        nvec++;
        chk("wrap_count", 0, word_count, 8'd0);

        @(posedge clk); #1 din_valid = 1'b1; din = 8'hC3;
        @(posedge clk); #1 din_valid = 1'b0;
        cyc = 0;
        do begin @(negedge clk); cyc++; end while (busy && cyc < 50);
        nvec++;
        chk("count_257_idle", 0, {7'd0, busy}, 8'd0);
        nvec++;
        chk("count_257", 0, word_count, 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
